// File: rtl/vending_display_driver.sv
// Four-digit multiplexed seven-segment front end: "XX.XX" money readout via a
// sequential double-dabble converter, or a scrolling text message.
module vending_display_driver #(
  parameter int REFRESH_DIV = 50_000,
  parameter int SCROLL_DIV  = 12_500_000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [2:0]  scrollMode,
  input  logic        showMoney,
  input  logic [11:0] amountDisplay,
  output logic [6:0]  seg,
  output logic        dp,
  output logic [3:0]  an
);
  localparam int NUM_DIG = 4;
  localparam int RW      = $clog2(REFRESH_DIV + 1);
  localparam int SW      = $clog2(SCROLL_DIV + 1);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SHIFT} bcd_st_t;

  function automatic logic [6:0] nib_glyph(input logic [3:0] n);
    case (n)
      4'd0: nib_glyph = 7'h40;
      4'd1: nib_glyph = 7'h79;
      4'd2: nib_glyph = 7'h24;
      4'd3: nib_glyph = 7'h30;
      4'd4: nib_glyph = 7'h19;
      4'd5: nib_glyph = 7'h12;
      4'd6: nib_glyph = 7'h02;
      4'd7: nib_glyph = 7'h78;
      4'd8: nib_glyph = 7'h00;
      4'd9: nib_glyph = 7'h10;
      default: nib_glyph = 7'h7F;
    endcase
  endfunction

  // Characters past the end of the message are the trailing blanks of the scroll loop.
  function automatic logic [6:0] msg_glyph(input logic [2:0] m, input logic [4:0] k);
    msg_glyph = 7'h7F;
    case (m)
      3'd0: case (k)
        5'd0: msg_glyph = 7'h09;
        5'd1: msg_glyph = 7'h06;
        5'd2: msg_glyph = 7'h47;
        5'd3: msg_glyph = 7'h47;
        5'd4: msg_glyph = 7'h40;
        default: msg_glyph = 7'h7F;
      endcase
      3'd1: case (k)
        5'd0: msg_glyph = 7'h12;
        5'd1: msg_glyph = 7'h06;
        5'd2: msg_glyph = 7'h47;
        5'd3: msg_glyph = 7'h06;
        5'd4: msg_glyph = 7'h46;
        5'd5: msg_glyph = 7'h07;
        default: msg_glyph = 7'h7F;
      endcase
      3'd2: case (k)
        5'd0: msg_glyph = 7'h0C;
        5'd1: msg_glyph = 7'h08;
        5'd2: msg_glyph = 7'h11;
        default: msg_glyph = 7'h7F;
      endcase
      3'd3: case (k)
        5'd0: msg_glyph = 7'h12;
        5'd1: msg_glyph = 7'h40;
        5'd2: msg_glyph = 7'h47;
        5'd3: msg_glyph = 7'h21;
        5'd4: msg_glyph = 7'h7F;
        5'd5: msg_glyph = 7'h40;
        5'd6: msg_glyph = 7'h41;
        5'd7: msg_glyph = 7'h07;
        default: msg_glyph = 7'h7F;
      endcase
      3'd4: case (k)
        5'd0: msg_glyph = 7'h06;
        5'd1: msg_glyph = 7'h48;
        5'd2: msg_glyph = 7'h61;
        5'd3: msg_glyph = 7'h40;
        5'd4: msg_glyph = 7'h11;
        default: msg_glyph = 7'h7F;
      endcase
      default: msg_glyph = 7'h7F;
    endcase
  endfunction

  function automatic logic [4:0] msg_len(input logic [2:0] m);
    case (m)
      3'd0:    msg_len = 5'd9;
      3'd1:    msg_len = 5'd10;
      3'd2:    msg_len = 5'd7;
      3'd3:    msg_len = 5'd12;
      3'd4:    msg_len = 5'd9;
      default: msg_len = 5'd4;
    endcase
  endfunction

  // One double-dabble step over {bcd[15:0], bin[11:0]}.
  function automatic logic [27:0] dabble(input logic [27:0] v);
    logic [27:0] t;
    t = v;
    for (int i = 0; i < NUM_DIG; i++)
      if (t[12+4*i +: 4] >= 4'd5) t[12+4*i +: 4] = t[12+4*i +: 4] + 4'd3;
    dabble = {t[26:0], 1'b0};
  endfunction

  logic [1:0]    idx_q, idx_d;
  logic [RW-1:0] ref_q, ref_d;
  logic [SW-1:0] scr_q, scr_d;
  logic [3:0]    pos_q, pos_d;
  logic [3:0]    mode_q;
  logic [15:0]   bcd_q, bcd_d;
  bcd_st_t       st_q, st_d;
  logic [27:0]   sh_q, sh_d, sh_step;
  logic [3:0]    cnt_q, cnt_d;
  logic [11:0]   amt_q, amt_d;
  logic [6:0]    seg_q;
  logic          dp_q;
  logic [3:0]    an_q;
  logic [4:0]    len;
  logic [3:0]    mode_in;

  logic [NUM_DIG-1:0][6:0] dig_seg;

  assign mode_in = {showMoney, scrollMode};
  assign len     = msg_len(mode_q[2:0]);
  assign sh_step = dabble(sh_q);

  for (genvar g = 0; g < NUM_DIG; g++) begin : g_dig
    logic [4:0] k_raw, k;
    logic [3:0] nib;
    logic [6:0] glyph;
    assign nib = bcd_q[4*g +: 4];
    always_comb begin
      k_raw = {1'b0, pos_q} + 5'(NUM_DIG - 1 - g);
      k     = (k_raw >= len) ? k_raw - len : k_raw;
      if (mode_q[3])
        glyph = (g == NUM_DIG - 1 && nib == 4'd0) ? 7'h7F : nib_glyph(nib);
      else
        glyph = msg_glyph(mode_q[2:0], k);
    end
    assign dig_seg[g] = glyph;
  end

  always_comb begin
    idx_d = idx_q;
    ref_d = ref_q + RW'(1);
    if (ref_q == RW'(REFRESH_DIV - 1)) begin
      ref_d = '0;
      idx_d = idx_q + 2'd1;
    end
  end

  // A mode change restarts the scroll from the first character.
  always_comb begin
    pos_d = pos_q;
    scr_d = scr_q + SW'(1);
    if (mode_in != mode_q) begin
      pos_d = '0;
      scr_d = '0;
    end else if (scr_q == SW'(SCROLL_DIV - 1)) begin
      scr_d = '0;
      pos_d = ({1'b0, pos_q} + 5'd1 == len) ? 4'd0 : pos_q + 4'd1;
    end
  end

  always_comb begin
    st_d  = st_q;
    sh_d  = sh_q;
    cnt_d = cnt_q;
    amt_d = amt_q;
    bcd_d = bcd_q;
    case (st_q)
      S_IDLE: if (amountDisplay != amt_q) st_d = S_LOAD;
      S_LOAD: begin
        amt_d = amountDisplay;
        sh_d  = {16'h0, amountDisplay};
        cnt_d = '0;
        st_d  = S_SHIFT;
      end
      S_SHIFT: begin
        sh_d  = sh_step;
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == 4'd11) begin
          bcd_d = sh_step[27:12];
          st_d  = S_IDLE;
        end
      end
      default: st_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      idx_q  <= '0;
      ref_q  <= '0;
      scr_q  <= '0;
      pos_q  <= '0;
      mode_q <= '0;
      bcd_q  <= '0;
      st_q   <= S_IDLE;
      sh_q   <= '0;
      cnt_q  <= '0;
      amt_q  <= '0;
      seg_q  <= 7'h7F;
      dp_q   <= 1'b1;
      an_q   <= 4'hF;
    end else begin
      idx_q  <= idx_d;
      ref_q  <= ref_d;
      scr_q  <= scr_d;
      pos_q  <= pos_d;
      mode_q <= mode_in;
      bcd_q  <= bcd_d;
      st_q   <= st_d;
      sh_q   <= sh_d;
      cnt_q  <= cnt_d;
      amt_q  <= amt_d;
      seg_q  <= dig_seg[idx_q];
      dp_q   <= ~(mode_q[3] && idx_q == 2'd2);
      an_q   <= ~(4'b0001 << idx_q);
    end
  end

  assign seg = seg_q;
  assign dp  = dp_q;
  assign an  = an_q;

endmodule

// File: tb/tb_vending_display_driver.sv
// Scoreboard bench for vending_display_driver with short refresh/scroll periods.
module tb_vending_display_driver;
  localparam int RDIV = 4;
  localparam int SDIV = 16;

  typedef struct {
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
  } exp_t;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [2:0]  scrollMode = 3'd2;
  logic        showMoney = 1'b0;
  logic [11:0] amountDisplay = 12'd0;
  logic [6:0]  seg;
  logic        dp;
  logic [3:0]  an;

  int   n_cmp = 0;
  int   n_err = 0;
  exp_t sb[$];

  string msg[8] = '{"HELLO", "SELECT", "PAY", "SOLD OUT", "ENJOY", "", "", ""};

  vending_display_driver #(.REFRESH_DIV(RDIV), .SCROLL_DIV(SDIV)) dut (
    .clock(clock), .reset(reset), .scrollMode(scrollMode), .showMoney(showMoney),
    .amountDisplay(amountDisplay), .seg(seg), .dp(dp), .an(an)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [6:0] cglyph(input byte c);
    case (c)
      "0": cglyph = 7'h40;  "1": cglyph = 7'h79;  "2": cglyph = 7'h24;
      "3": cglyph = 7'h30;  "4": cglyph = 7'h19;  "5": cglyph = 7'h12;
      "6": cglyph = 7'h02;  "7": cglyph = 7'h78;  "8": cglyph = 7'h00;
      "9": cglyph = 7'h10;  "A": cglyph = 7'h08;  "C": cglyph = 7'h46;
      "D": cglyph = 7'h21;  "E": cglyph = 7'h06;  "H": cglyph = 7'h09;
      "J": cglyph = 7'h61;  "L": cglyph = 7'h47;  "N": cglyph = 7'h48;
      "O": cglyph = 7'h40;  "P": cglyph = 7'h0C;  "S": cglyph = 7'h12;
      "T": cglyph = 7'h07;  "U": cglyph = 7'h41;  "Y": cglyph = 7'h11;
      default: cglyph = 7'h7F;
    endcase
  endfunction

  function automatic logic [6:0] txt_seg(input int mode, input int pos, input int d);
    string m;
    int n, k;
    m = msg[mode];
    n = m.len() + 4;
    k = (pos + 3 - d) % n;
    txt_seg = (k < m.len()) ? cglyph(m[k]) : 7'h7F;
  endfunction

  function automatic logic [6:0] money_seg(input int amt, input int d);
    int div[4] = '{1, 10, 100, 1000};
    int dig;
    dig = (amt / div[d]) % 10;
    money_seg = (d == 3 && dig == 0) ? 7'h7F : cglyph(byte'(48 + dig));
  endfunction

  // One 16-cycle refresh frame, starting on a frame boundary; each digit sampled
  // in its last enabled cycle.
  task automatic frame(input string name, input bit money, input int amt, input int mode,
                       input int pos, input bit chk_first);
    exp_t e;
    for (int d = 0; d < 4; d++) begin
      e.an  = ~(4'b0001 << d);
      e.seg = money ? money_seg(amt, d) : txt_seg(mode, pos, d);
      e.dp  = !(money && d == 2);
      sb.push_back(e);
    end
    for (int c = 1; c <= 16; c++) begin
      @(negedge clock);
      if (chk_first && c == 1) chk({name, " an_first"}, 16'(an), 16'h000E);
      if (c % 4 == 0) begin
        e = sb.pop_front();
        chk($sformatf("%s d%0d an", name, c / 4 - 1), 16'(an), 16'(e.an));
        chk($sformatf("%s d%0d seg", name, c / 4 - 1), 16'(seg), 16'(e.seg));
        chk($sformatf("%s d%0d dp", name, c / 4 - 1), 16'(dp), 16'(e.dp));
      end
    end
  endtask

  task automatic skip_frame();
    repeat (16) @(negedge clock);
  endtask

  task automatic chk_reset_outs(input string name);
    chk({name, " seg"}, 16'(seg), 16'h007F);
    chk({name, " an"}, 16'(an), 16'h000F);
    chk({name, " dp"}, 16'(dp), 16'h0001);
  endtask

  initial begin
    exp_t e;
    int   amt, idx;

    repeat (3) @(negedge clock);
    chk_reset_outs("por");

    // PAY scroll through a full wrap: frame f shows position f
    reset = 1'b0;
    for (int p = 0; p < 8; p++) frame($sformatf("pay p%0d", p), 0, 0, 2, p, p == 0);

    // async reset mid-scroll, then SOLD OUT from p=0
    repeat (20) @(negedge clock);
    #2 reset = 1'b1;
    #1 chk_reset_outs("async rst");
    scrollMode = 3'd3;
    @(negedge clock);
    reset = 1'b0;
    for (int p = 0; p < 6; p++) frame($sformatf("sold p%0d", p), 0, 0, 3, p, p == 0);

    // switch message at p=5: restarts at p=0
    scrollMode = 3'd4;
    frame("enjoy p0", 0, 0, 4, 0, 0);
    frame("enjoy p1", 0, 0, 4, 1, 0);

    // money mode from reset
    reset = 1'b1;
    showMoney = 1'b1;
    amountDisplay = 12'd1234;
    @(negedge clock);
    reset = 1'b0;
    skip_frame();
    frame("m1234", 1, 1234, 0, 0, 0);
    foreach (msg[i]) begin end
    amountDisplay = 12'd5;    skip_frame(); frame("m5", 1, 5, 0, 0, 0);
    amountDisplay = 12'd0;    skip_frame(); frame("m0", 1, 0, 0, 0, 0);
    amountDisplay = 12'd1000; skip_frame(); frame("m1000", 1, 1000, 0, 0, 0);
    amountDisplay = 12'd4095; skip_frame(); frame("m4095", 1, 4095, 0, 0, 0);

    // back to text, and a blank message
    showMoney = 1'b0;
    scrollMode = 3'd1;
    frame("select p0", 0, 0, 1, 0, 0);
    scrollMode = 3'd5;
    frame("blank", 0, 0, 5, 0, 0);

    // change amount during SHIFT cycle 6: 4095 shown whole, then 10
    reset = 1'b1;
    showMoney = 1'b1;
    amountDisplay = 12'd4095;
    @(negedge clock);
    reset = 1'b0;
    for (int k = 1; k <= 48; k++) begin
      @(negedge clock);
      if (k == 7) amountDisplay = 12'd10;
      if (k >= 15) begin
        amt   = (k <= 28) ? 4095 : 10;
        idx   = ((k - 1) / 4) % 4;
        e.an  = ~(4'b0001 << idx);
        e.seg = money_seg(amt, idx);
        e.dp  = (idx != 2);
        sb.push_back(e);
        e = sb.pop_front();
        chk($sformatf("tear k%0d an", k), 16'(an), 16'(e.an));
        chk($sformatf("tear k%0d seg", k), 16'(seg), 16'(e.seg));
        chk($sformatf("tear k%0d dp", k), 16'(dp), 16'(e.dp));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
